// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit, the ALU decode
// and the HI/LO register pair.
package muldiv_unit_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [3:0] ALU_MULT = 4'b1011;
  localparam logic [3:0] ALU_DIV  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: out = neg ? ~in + carry_in : in.
// carry_in lets two instances chain into a double-width negation.
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_val,
  input  logic             neg,
  input  logic             carry_in,
  output logic [WIDTH-1:0] out_val
);

  assign out_val = neg ? (~in_val + {{(WIDTH-1){1'b0}}, carry_in}) : in_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply / restoring divide feeding the HI/LO registers.
// Fixed latency: Done pulses WIDTH+2 cycles after the accepting edge.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             Start,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output state_t           dbg_state
);

  // Handshake: Start is a request sampled only in S_IDLE with a valid opcode;
  // there is no ready signal, Busy covers CALC and FIX, and Done is a
  // single-cycle write strobe with Hi/Lo already valid in that cycle.

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               op_div_q;
  logic               sign_q_q;
  logic               sign_r_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               valid_op;
  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   lo_fix, hi_fix;
  logic               hi_neg, hi_cin;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;

  assign valid_op  = (ALU_control == ALU_MULT) || (ALU_control == ALU_DIV);
  assign accept    = (state_q == S_IDLE) && Start && valid_op;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (
    .in_val(A), .neg(A[WIDTH-1]), .carry_in(1'b1), .out_val(abs_a)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (
    .in_val(B), .neg(B[WIDTH-1]), .carry_in(1'b1), .out_val(abs_b)
  );

  // For a product the high half only gets the +1 when the low half is zero,
  // which turns the two instances into one 2*WIDTH negation.
  assign hi_neg = op_div_q ? sign_r_q : sign_q_q;
  assign hi_cin = op_div_q ? 1'b1 : (acc_q[WIDTH-1:0] == '0);

  muldiv_negate #(.WIDTH(WIDTH)) u_fix_lo (
    .in_val(acc_q[WIDTH-1:0]), .neg(sign_q_q), .carry_in(1'b1), .out_val(lo_fix)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_fix_hi (
    .in_val(acc_q[2*WIDTH-1:WIDTH]), .neg(hi_neg), .carry_in(hi_cin), .out_val(hi_fix)
  );

  // One iteration: acc holds {P, multiplier} for mult, {remainder, quotient} for div.
  always_comb begin
    add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    acc_next  = acc_q;
    if (op_div_q) begin
      if (!div_diff[WIDTH]) acc_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {add_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  if (last_iter) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      op_div_q   <= 1'b0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q      <= '0;
            op_div_q   <= (ALU_control == ALU_DIV);
            sign_q_q   <= A[WIDTH-1] ^ B[WIDTH-1];
            sign_r_q   <= A[WIDTH-1];
            div_zero_q <= (B == '0);
            if (ALU_control == ALU_DIV) begin
              acc_q  <= {{WIDTH{1'b0}}, abs_a};
              opnd_q <= abs_b;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, abs_b};
              opnd_q <= abs_a;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_FIX: begin
          // With a zero divisor the remainder path already reproduces A.
          hi_q <= hi_fix;
          lo_q <= (op_div_q && div_zero_q) ? {WIDTH{1'b1}} : lo_fix;
        end
        default: ;
      endcase
    end
  end

  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign Busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign Done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule
